// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI slave front end and its surroundings: SPI pins on one side,
// the core byte handshake on the other.
interface spi_slave_if_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] rx_data;
    logic              data_rdy;
    logic [DATA_W-1:0] tx_data;
    logic              tx_latch;
    logic              frame_active;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_latch,
        output miso, miso_oe, rx_data, data_rdy, frame_active
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_latch,
        input  miso, miso_oe, rx_data, data_rdy, frame_active
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave, fully oversampled on sys_clk: MOSI bytes out to the core with a data_rdy
// pulse, the core's held byte shifted out on MISO.
//   state  | meaning
//   IDLE   | cs_n high (or not yet armed after reset); sclk edges ignored, MISO released
//   ACTIVE | frame in progress; shift on synchronised sclk edges, MISO driven
module spi_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic            sys_clk,
    input  logic            rst,
    spi_slave_if_if.slave   bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_dly_q, cs_dly_q, armed_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              data_rdy_q, data_rdy_d;
    logic              miso_q, miso_d;
    logic              load_pending_q, load_pending_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;

    // armed_q blocks the false cs_fall seen when reset releases with cs_n already low:
    // a frame may only start after a genuine high sample of cs_n has passed the synchroniser.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            fill_q      <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            tx_hold_q      <= '0;
            rx_data_q      <= '0;
            data_rdy_q     <= 1'b0;
            miso_q         <= 1'b0;
            load_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            tx_hold_q      <= tx_hold_d;
            rx_data_q      <= rx_data_d;
            data_rdy_q     <= data_rdy_d;
            miso_q         <= miso_d;
            load_pending_q <= load_pending_d;
        end
    end

    // miso_q is the transmit MSB; tx_shift_q holds the remaining bits still to go out.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        tx_hold_d      = bus.tx_latch ? bus.tx_data : tx_hold_q;
        rx_data_d      = rx_data_q;
        data_rdy_d     = 1'b0;
        miso_d         = miso_q;
        load_pending_d = load_pending_q;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d        = ACTIVE;
                    bit_cnt_d      = '0;
                    miso_d         = tx_hold_q[DATA_W-1];
                    tx_shift_d     = tx_hold_q[DATA_W-2:0];
                    load_pending_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d      = '0;
                        rx_data_d      = {rx_shift_q, mosi_s};
                        data_rdy_d     = 1'b1;
                        load_pending_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (load_pending_q) begin
                        miso_d         = tx_hold_q[DATA_W-1];
                        tx_shift_d     = tx_hold_q[DATA_W-2:0];
                        load_pending_d = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-2];
                        tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.miso         = miso_q;
    assign bus.miso_oe      = (state_q == ACTIVE);
    assign bus.frame_active = (state_q == ACTIVE);
    assign bus.rx_data      = rx_data_q;
    assign bus.data_rdy     = data_rdy_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a mode-0 master drives directed bytes; expected received bytes are
// queued at issue time and a monitor pops them on every data_rdy pulse.
module tb_spi_slave_if;
    logic sys_clk = 1'b0;
    logic rst     = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_slave_if_if #(.DATA_W(8)) bus ();

    spi_slave_if #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_rdy = 1'b0;
    logic [7:0] got;
    logic       oe_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every data_rdy pulse must match the oldest queued byte and last one cycle.
    always @(negedge sys_clk) begin
        if (prev_rdy) check("rdy_width", {31'd0, bus.data_rdy}, 32'd0);
        if (bus.data_rdy) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_rdy: got pulse with rx_data %0h, expected no pulse",
                         bus.rx_data);
            end else begin
                check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_rdy <= bus.data_rdy;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Mode-0 master: shifts nbits of b MSB first (sclk = sys_clk/8), sampling MISO just
    // before each rising edge. Optionally latches a new tx byte during the last high phase.
    task automatic xfer(input logic [7:0] b, input int nbits, input bit do_latch,
                        input logic [7:0] latch_val);
        got   = '0;
        oe_ok = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            cycles(4);
            got[i] = bus.miso;
            oe_ok  = oe_ok & bus.miso_oe;
            bus.sclk = 1'b1;
            if (i == 0 && do_latch) begin
                cycles(3);
                bus.tx_data  = latch_val;
                bus.tx_latch = 1'b1;
                cycles(1);
                bus.tx_latch = 1'b0;
            end else begin
                cycles(4);
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] miso_exp,
                             input bit do_latch, input logic [7:0] latch_val);
        exp_q.push_back(b);
        xfer(b, 8, do_latch, latch_val);
        check("miso_byte", {24'd0, got}, {24'd0, miso_exp});
        check("miso_oe_in_frame", {31'd0, oe_ok}, 32'd1);
    endtask

    task automatic start_frame();
        bus.cs_n = 1'b0;
        cycles(4);
    endtask

    task automatic end_frame();
        cycles(4);
        bus.cs_n = 1'b1;
        cycles(8);
    endtask

    task automatic check_idle(input string name, input logic [7:0] rx_exp);
        check({name, "_rx_data"}, {24'd0, bus.rx_data}, {24'd0, rx_exp});
        check({name, "_miso_oe"}, {31'd0, bus.miso_oe}, 32'd0);
        check({name, "_frame_active"}, {31'd0, bus.frame_active}, 32'd0);
        check({name, "_miso"}, {31'd0, bus.miso}, 32'd0);
    endtask

    initial begin
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_latch = 1'b0;

        // Reset values
        cycles(5);
        rst = 1'b1;
        cycles(2);
        check_idle("reset", 8'h00);
        check("reset_data_rdy", {31'd0, bus.data_rdy}, 32'd0);

        // Single byte: MOSI 0x3C, MISO from held 0xA5
        bus.tx_data  = 8'hA5;
        bus.tx_latch = 1'b1;
        cycles(1);
        bus.tx_latch = 1'b0;
        cycles(4);
        start_frame();
        check("frame_active_on", {31'd0, bus.frame_active}, 32'd1);
        send_byte(8'h3C, 8'hA5, 1'b0, 8'h00);
        end_frame();

        // Three back-to-back bytes, tx updated after each completion
        start_frame();
        send_byte(8'h81, 8'hA5, 1'b1, 8'h11);
        send_byte(8'h7E, 8'h11, 1'b1, 8'h22);
        send_byte(8'hFF, 8'h22, 1'b0, 8'h00);
        end_frame();

        // Aborted partial byte, then a full frame
        start_frame();
        xfer(8'hA0, 5, 1'b0, 8'h00);
        end_frame();
        check_idle("abort", 8'hFF);
        start_frame();
        send_byte(8'h55, 8'h22, 1'b0, 8'h00);
        end_frame();

        // Reset mid-frame with cs_n held low; the aborted frame must not resume
        start_frame();
        xfer(8'hE0, 3, 1'b0, 8'h00);
        rst = 1'b0;
        cycles(2);
        check_idle("rst_held", 8'h00);
        rst = 1'b1;
        xfer(8'h96, 8, 1'b0, 8'h00);
        cycles(4);
        check_idle("post_rst", 8'h00);
        bus.cs_n = 1'b1;
        cycles(8);
        start_frame();
        send_byte(8'hC3, 8'h00, 1'b0, 8'h00);
        end_frame();

        // cs_n rises together with the 8th sclk rise: edge dropped
        start_frame();
        xfer(8'h5A, 7, 1'b0, 8'h00);
        bus.mosi = 1'b0;
        cycles(4);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        cycles(4);
        bus.sclk = 1'b0;
        cycles(8);
        check_idle("cs_rise_coincident", 8'hC3);

        // Block still works afterwards
        start_frame();
        send_byte(8'h96, 8'h00, 1'b0, 8'h00);
        end_frame();

        cycles(4);
        check("pending_expected", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
